drp_adc_responder: RTL and testbench
====================================

# drp_adc_responder

Synthesizable DRP responder that plays the XADC side of the dynamic reconfiguration port. It presents the XADC status and configuration register map, runs a channel sequencer that paces conversions and raises EOC/EOS, and captures externally supplied sample data into the result registers. The block drops in where the XADC hard macro sits, so the DRP initiator and the game-speed logic can run on devices or benches without the hard macro.

## Interface
- RD_LATENCY, 4: DCLK cycles from an accepted DEN to DRDY; legal range 1..15.
- CONV_CYCLES, 26: DCLK cycles per conversion; legal range 2..255.
- DCLK  in  1  clock; single clock domain.
- RESET  in  1  reset; asynchronous, active-high.
- DADDR  in  7  DRP address.
- DEN  in  1  DRP enable, one-cycle strobe.
- DWE  in  1  DRP write enable, qualified by DEN.
- DI  in  16  DRP write data.
- DO  out  16  DRP read data; valid only while DRDY=1, otherwise 0.
- DRDY  out  1  one-cycle transaction-complete pulse.
- BUSY  out  1  high while a conversion is in progress.
- CHANNEL  out  5  channel of the current or last conversion.
- EOC  out  1  one-cycle pulse at the end of each conversion.
- EOS  out  1  one-cycle pulse coincident with the EOC of the last channel in a sequence.
- SAMPLE_DATA  in  16  analog value for the current CHANNEL, sampled on the EOC edge.

## Operation
- Reset values: DO=0, DRDY=0, BUSY=0, CHANNEL=0, EOC=0, EOS=0. Result registers 0x00–0x3F reset to 0. Config reset values: 0x40=9000, 0x41=2EF0, 0x42=0400, 0x48=4701, 0x49=000F; all other config registers 0.
- DRP FSM states: IDLE, WAIT.
  - IDLE: DEN=1 captures DADDR, DWE and DI, loads the latency counter, and moves to WAIT.
  - WAIT: the counter reaches 0, then DRDY=1 for one cycle, then return to IDLE.
  - A DEN that arrives during WAIT is ignored and sets sticky bit 0 of status register 0x3F. A DRP read of 0x3F clears that bit.
- Register map:
  - 0x00–0x3F: read-only; writes are discarded but still receive DRDY.
  - 0x40–0x5F: read/write.
  - 0x60–0x7F: reads return 0, writes are discarded.
- Reads: DO is loaded from the register file on the DRDY edge, using the value before any same-edge sequencer update. Writes commit on the DRDY edge.
- Sequencer mode is SEQ = reg41[15:12]:
  - 4'h2: continuous.
  - 4'h1: single pass; stops after EOS.
  - Any other value: halted, BUSY=0.
- Enabled channels:
  - reg48 bit 8 → ch0, bit 9 → ch1, bit 10 → ch2, bit 14 → ch6, bit 0 → ch8.
  - reg49 bit n → ch16+n.
  - Channels convert in ascending channel order.
- Sequencer FSM states: HALT, CONV, NEXT.
  - CONV: BUSY=1 for CONV_CYCLES cycles. On the last cycle: result[CHANNEL] <= SAMPLE_DATA & 16'hFFF0, EOC=1, and EOS=1 if this is the last enabled channel.
  - NEXT: selects the next enabled channel and updates CHANNEL. After the last channel it wraps to the lowest enabled channel, or goes to HALT in single-pass mode.
  - If no channel is enabled, the sequencer stays in HALT.
- A committed write to 0x41, 0x48 or 0x49 aborts any conversion in progress (no EOC) and restarts the sequence at the lowest enabled channel on the next cycle.
- An EOC and a DRP write to a config register on the same edge both take effect; the restart rule then applies.

## Timing
- DEN accepted at edge k → DRDY and DO at edge k+RD_LATENCY. Back-to-back transactions: the next DEN is accepted at the earliest on edge k+RD_LATENCY+1.
- The first conversion begins on the first edge after RESET deasserts.
- EOC period is CONV_CYCLES+1 cycles (CONV plus one NEXT cycle). BUSY is low during the NEXT cycle.
- With default config, 9 channels are enabled (0, 1, 2, 6, 8, 16–19), so EOS repeats every 9×(CONV_CYCLES+1) cycles.
- Asserting RESET mid-transaction discards the pending DRP access with no DRDY, and aborts the conversion in progress.

## Configuration
- Macro DRP_RESP_MINMAX_EN.
- Defined: on each EOC, min/max tracking registers are updated:
  - ch0 (temperature): max at 0x20, min at 0x24.
  - ch1 (VCCINT): max at 0x21, min at 0x25.
  - Reset values: max = 0000, min = FFFF.
- Undefined: addresses 0x20, 0x21, 0x24 and 0x25 read 0, and no comparators are built.

## Structure
- Package drp_resp_pkg holds:
  - register address constants;
  - config reset values;
  - SEQ mode codes;
  - the channel-enable bit mapping;
  - the FSM state enumerations.
- Sub-module drp_resp_sequencer contains the conversion FSM, the channel selection and the EOC/EOS generation. The top level owns the DRP FSM and the register file.

## Test plan
- Reset, then read 0x41 with RD_LATENCY=4 → DRDY exactly 4 cycles after DEN, DO=2EF0; DO=0 on all other cycles.
- Default config, SAMPLE_DATA=ABCD → EOC every CONV_CYCLES+1 cycles, CHANNEL steps 0,1,2,6,8,16,17,18,19, EOS on the ch19 EOC, reg 0x11 reads ABC0.
- Write 0x49=0002 mid-conversion of ch17 → no EOC for that conversion, sequence restarts at ch0, and ch16 never converts again.
- Write 0x41=1EF0 → exactly one EOS, then BUSY stays 0 and EOC stays 0.
- Second DEN one cycle after the first → only one DRDY; a read of 0x3F returns bit 0 = 1, and a second read of 0x3F returns bit 0 = 0.
- Build with DRP_RESP_MINMAX_EN, ch0 samples 4000, 8000, 2000 → 0x20=8000, 0x24=2000. Without the macro, both addresses read 0.

Source files
------------

// File: rtl/drp_resp_pkg.sv
// drp_resp_pkg -- shared constants for the XADC-style DRP responder.
// Holds register addresses, config reset values, sequencer mode codes,
// the channel-enable bit mapping and the FSM state encodings.
package drp_resp_pkg;

  // Register addresses
  localparam logic [6:0] ADDR_MAX_TEMP   = 7'h20;
  localparam logic [6:0] ADDR_MAX_VCCINT = 7'h21;
  localparam logic [6:0] ADDR_MIN_TEMP   = 7'h24;
  localparam logic [6:0] ADDR_MIN_VCCINT = 7'h25;
  localparam logic [6:0] ADDR_STATUS     = 7'h3F;
  localparam logic [6:0] ADDR_CFG1       = 7'h41;
  localparam logic [6:0] ADDR_SEQ0       = 7'h48;
  localparam logic [6:0] ADDR_SEQ1       = 7'h49;

  // Config reset values
  localparam logic [15:0] CFG0_RST = 16'h9000;
  localparam logic [15:0] CFG1_RST = 16'h2EF0;
  localparam logic [15:0] CFG2_RST = 16'h0400;
  localparam logic [15:0] SEQ0_RST = 16'h4701;
  localparam logic [15:0] SEQ1_RST = 16'h000F;

  // Sequencer mode codes (reg41[15:12])
  localparam logic [3:0] SEQ_SINGLE = 4'h1;
  localparam logic [3:0] SEQ_CONT   = 4'h2;

  // DRP FSM states
  localparam logic DRP_IDLE = 1'b0;
  localparam logic DRP_WAIT = 1'b1;

  // Sequencer FSM states
  localparam logic [1:0] SEQ_HALT = 2'd0;
  localparam logic [1:0] SEQ_CONV = 2'd1;
  localparam logic [1:0] SEQ_NEXT = 2'd2;

  // Reset value of config register 0x40+idx
  function automatic logic [15:0] cfg_reset(input logic [4:0] idx);
    case (idx)
      5'h00:   cfg_reset = CFG0_RST;
      5'h01:   cfg_reset = CFG1_RST;
      5'h02:   cfg_reset = CFG2_RST;
      5'h08:   cfg_reset = SEQ0_RST;
      5'h09:   cfg_reset = SEQ1_RST;
      default: cfg_reset = 16'h0000;
    endcase
  endfunction

  // Map the two sequence-select registers onto a flat 32-channel mask
  function automatic logic [31:0] chan_enable(input logic [15:0] seq0,
                                              input logic [15:0] seq1);
    logic [31:0] m;
    m        = '0;
    m[0]     = seq0[8];
    m[1]     = seq0[9];
    m[2]     = seq0[10];
    m[6]     = seq0[14];
    m[8]     = seq0[0];
    m[31:16] = seq1;
    return m;
  endfunction

  // Lowest set bit index (0 when empty; callers qualify with |m)
  function automatic logic [4:0] lowest_ch(input logic [31:0] m);
    logic [4:0] ch;
    ch = '0;
    for (int i = 31; i >= 0; i--)
      if (m[i]) ch = 5'(i);
    return ch;
  endfunction

  // Enabled channels strictly above cur
  function automatic logic [31:0] above_mask(input logic [31:0] m,
                                             input logic [4:0]  cur);
    logic [31:0] r;
    for (int i = 0; i < 32; i++)
      r[i] = m[i] && (i > int'(cur));
    return r;
  endfunction

endpackage

// File: rtl/drp_resp_sequencer.sv
// drp_resp_sequencer -- conversion pacing, channel selection, EOC/EOS.
// Ports:
//   DCLK, RESET       clock / async active-high reset
//   restart           one-cycle pulse: abort and restart at lowest channel
//   seq_mode[3:0]     reg41[15:12]
//   chan_en[31:0]     enabled-channel mask
//   busy              high during CONV
//   channel[4:0]      current / last converted channel
//   eoc, eos          registered end-of-conversion / end-of-sequence pulses
//   conv_done         combinational: this edge ends a conversion (capture strobe)
module drp_resp_sequencer
  import drp_resp_pkg::*;
#(
  parameter int CONV_CYCLES = 26
) (
  input  logic        DCLK,
  input  logic        RESET,
  input  logic        restart,
  input  logic [3:0]  seq_mode,
  input  logic [31:0] chan_en,
  output logic        busy,
  output logic [4:0]  channel,
  output logic        eoc,
  output logic        eos,
  output logic        conv_done
);

  localparam logic [7:0] CNT_LAST = 8'(CONV_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic        done;   // single pass finished; hold off until restart
  logic        run, any_en, last;
  logic [31:0] higher;

  assign run       = (seq_mode == SEQ_CONT) || (seq_mode == SEQ_SINGLE);
  assign any_en    = |chan_en;
  assign higher    = above_mask(chan_en, channel);
  assign last      = ~|higher;
  assign busy      = (state == SEQ_CONV);
  // restart wins over a completing conversion, so an aborted one never EOCs
  assign conv_done = (state == SEQ_CONV) && (cnt == CNT_LAST) && !restart;

  always_ff @(posedge DCLK or posedge RESET) begin
    if (RESET) begin
      state   <= SEQ_HALT;
      cnt     <= '0;
      channel <= '0;
      eoc     <= 1'b0;
      eos     <= 1'b0;
      done    <= 1'b0;
    end else begin
      eoc <= conv_done;
      eos <= conv_done && last;
      if (restart) begin
        done <= 1'b0;
        cnt  <= '0;
        if (run && any_en) begin
          channel <= lowest_ch(chan_en);
          state   <= SEQ_CONV;
        end else begin
          state <= SEQ_HALT;
        end
      end else begin
        case (state)
          SEQ_HALT: if (run && any_en && !done) begin
            channel <= lowest_ch(chan_en);
            cnt     <= '0;
            state   <= SEQ_CONV;
          end
          SEQ_CONV: begin
            if (cnt == CNT_LAST) state <= SEQ_NEXT;
            else                 cnt   <= cnt + 8'd1;
          end
          SEQ_NEXT: begin
            cnt <= '0;
            if (!last) begin
              channel <= lowest_ch(higher);
              state   <= SEQ_CONV;
            end else if (seq_mode == SEQ_SINGLE) begin
              state <= SEQ_HALT;
              done  <= 1'b1;
            end else begin
              channel <= lowest_ch(chan_en);
              state   <= SEQ_CONV;
            end
          end
          default: state <= SEQ_HALT;
        endcase
      end
    end
  end

endmodule

// File: rtl/drp_adc_responder.sv
// drp_adc_responder -- XADC stand-in on the DRP: register map, DRP FSM and
// result capture; the channel sequencer lives in drp_resp_sequencer.
// Ports:
//   DCLK, RESET          clock / async active-high reset
//   DADDR, DEN, DWE, DI  DRP request
//   DO, DRDY             DRP response (DO is 0 unless DRDY)
//   BUSY, CHANNEL        conversion status
//   EOC, EOS             end of conversion / sequence pulses
//   SAMPLE_DATA          analog value for CHANNEL, captured on the EOC edge
// Optional: define DRP_RESP_MINMAX_EN to build ch0/ch1 min/max trackers
// at 0x20/0x24 and 0x21/0x25.
module drp_adc_responder
  import drp_resp_pkg::*;
#(
  parameter int RD_LATENCY  = 4,
  parameter int CONV_CYCLES = 26
) (
  input  logic        DCLK,
  input  logic        RESET,
  input  logic [6:0]  DADDR,
  input  logic        DEN,
  input  logic        DWE,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  output logic        DRDY,
  output logic        BUSY,
  output logic [4:0]  CHANNEL,
  output logic        EOC,
  output logic        EOS,
  input  logic [15:0] SAMPLE_DATA
);

  logic        drp_state;
  logic [3:0]  lat_cnt;
  logic [6:0]  addr_q;
  logic        we_q;
  logic [15:0] di_q;
  logic        ovf_sticky;
  logic        restart_q;
  logic [15:0] result [32];
  logic [15:0] cfg    [32];
  logic [15:0] rdata;
  logic [15:0] sample_m;
  logic        fire, wr_cfg, conv_done;

  assign fire     = (drp_state == DRP_WAIT) && (lat_cnt == 4'd0);
  assign wr_cfg   = fire && we_q && (addr_q[6:5] == 2'b10);
  assign sample_m = SAMPLE_DATA & 16'hFFF0;

`ifdef DRP_RESP_MINMAX_EN
  logic [15:0] max_temp, min_temp, max_vcc, min_vcc;

  always_ff @(posedge DCLK or posedge RESET) begin
    if (RESET) begin
      max_temp <= 16'h0000;
      min_temp <= 16'hFFFF;
      max_vcc  <= 16'h0000;
      min_vcc  <= 16'hFFFF;
    end else if (conv_done) begin
      if (CHANNEL == 5'd0) begin
        if (sample_m > max_temp) max_temp <= sample_m;
        if (sample_m < min_temp) min_temp <= sample_m;
      end
      if (CHANNEL == 5'd1) begin
        if (sample_m > max_vcc) max_vcc <= sample_m;
        if (sample_m < min_vcc) min_vcc <= sample_m;
      end
    end
  end
`endif

  // Read mux over the pre-edge register state
  always_comb begin
    rdata = 16'h0000;
    if (!addr_q[6]) begin
      if (!addr_q[5])                rdata = result[addr_q[4:0]];
      else if (addr_q == ADDR_STATUS) rdata = {15'b0, ovf_sticky};
`ifdef DRP_RESP_MINMAX_EN
      else if (addr_q == ADDR_MAX_TEMP)   rdata = max_temp;
      else if (addr_q == ADDR_MAX_VCCINT) rdata = max_vcc;
      else if (addr_q == ADDR_MIN_TEMP)   rdata = min_temp;
      else if (addr_q == ADDR_MIN_VCCINT) rdata = min_vcc;
`endif
    end else if (!addr_q[5]) begin
      rdata = cfg[addr_q[4:0]];
    end
  end

  // DRP FSM, response and sticky overlap flag
  always_ff @(posedge DCLK or posedge RESET) begin
    if (RESET) begin
      drp_state  <= DRP_IDLE;
      lat_cnt    <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      di_q       <= '0;
      DO         <= '0;
      DRDY       <= 1'b0;
      ovf_sticky <= 1'b0;
      restart_q  <= 1'b0;
    end else begin
      DRDY      <= fire;
      DO        <= (fire && !we_q) ? rdata : 16'h0000;
      // registered so the sequencer restarts against the new config
      restart_q <= wr_cfg && ((addr_q == ADDR_CFG1) || (addr_q == ADDR_SEQ0) ||
                              (addr_q == ADDR_SEQ1));
      if (DEN && drp_state == DRP_WAIT)
        ovf_sticky <= 1'b1;
      else if (fire && !we_q && addr_q == ADDR_STATUS)
        ovf_sticky <= 1'b0;
      case (drp_state)
        DRP_IDLE: if (DEN) begin
          addr_q    <= DADDR;
          we_q      <= DWE;
          di_q      <= DI;
          lat_cnt   <= 4'(RD_LATENCY - 1);
          drp_state <= DRP_WAIT;
        end
        default: begin
          if (lat_cnt == 4'd0) drp_state <= DRP_IDLE;
          else                 lat_cnt   <= lat_cnt - 4'd1;
        end
      endcase
    end
  end

  // Register file: config writes from DRP, results from the sequencer
  always_ff @(posedge DCLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) begin
        cfg[i]    <= cfg_reset(5'(i));
        result[i] <= 16'h0000;
      end
    end else begin
      if (wr_cfg)    cfg[addr_q[4:0]] <= di_q;
      if (conv_done) result[CHANNEL]  <= sample_m;
    end
  end

  drp_resp_sequencer #(.CONV_CYCLES(CONV_CYCLES)) u_seq (
    .DCLK      (DCLK),
    .RESET     (RESET),
    .restart   (restart_q),
    .seq_mode  (cfg[1][15:12]),
    .chan_en   (chan_enable(cfg[8], cfg[9])),
    .busy      (BUSY),
    .channel   (CHANNEL),
    .eoc       (EOC),
    .eos       (EOS),
    .conv_done (conv_done)
  );

endmodule

// File: tb/tb_drp_adc_responder.sv
// Directed bench for drp_adc_responder (RD_LATENCY=4, CONV_CYCLES=26).
// Build with DRP_RESP_MINMAX_EN to exercise the min/max trackers.
module tb_drp_adc_responder;

  logic        DCLK = 1'b0;
  logic        RESET;
  logic [6:0]  DADDR;
  logic        DEN, DWE;
  logic [15:0] DI, DO, SAMPLE_DATA;
  logic        DRDY, BUSY, EOC, EOS;
  logic [4:0]  CHANNEL;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, n_eoc = 0, n_eos = 0;

  drp_adc_responder #(.RD_LATENCY(4), .CONV_CYCLES(26)) dut (
    .DCLK(DCLK), .RESET(RESET), .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI),
    .DO(DO), .DRDY(DRDY), .BUSY(BUSY), .CHANNEL(CHANNEL), .EOC(EOC), .EOS(EOS),
    .SAMPLE_DATA(SAMPLE_DATA)
  );

  always #5 DCLK = ~DCLK;
  always @(posedge DCLK) cyc++;
  always @(negedge DCLK) begin
    if (EOC) n_eoc++;
    if (EOS) n_eos++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one DRP access at a negedge; returns at the negedge showing DRDY.
  // lat = edges from acceptance to DRDY; dz = OR of DO while DRDY low.
  task automatic drp(input logic [6:0] a, input logic w, input logic [15:0] d,
                     output logic [15:0] q, output int lat, output logic [15:0] dz);
    DADDR = a; DWE = w; DI = d; DEN = 1'b1;
    @(negedge DCLK);
    DEN = 1'b0; DWE = 1'b0;
    lat = 0; dz = '0;
    while (!DRDY && lat < 20) begin
      dz = dz | DO;
      @(negedge DCLK);
      lat++;
    end
    if (!DRDY) chk("drp_timeout", 32'(lat), 32'd4);
    q = DO;
  endtask

  task automatic wait_eoc(output int c);
    c = 0;
    do begin
      @(negedge DCLK);
      c++;
    end while (!EOC && c < 400);
    if (!EOC) chk("eoc_timeout", 0, 1);
  endtask

  initial begin
    logic [15:0] q, dz;
    int lat, c, r, e0, s0, act, nd, saw16;
    int exp_ch[9]  = '{0, 1, 2, 6, 8, 16, 17, 18, 19};
    int exp_ch2[6] = '{1, 2, 6, 8, 17, 0};
    logic [15:0] x20, x24, x21, x25;
`ifdef DRP_RESP_MINMAX_EN
    x20 = 16'h8000; x24 = 16'h2000; x21 = 16'h0000; x25 = 16'hFFFF;
`else
    x20 = 16'h0000; x24 = 16'h0000; x21 = 16'h0000; x25 = 16'h0000;
`endif

    RESET = 1'b1; DEN = 1'b0; DWE = 1'b0; DADDR = '0; DI = '0;
    SAMPLE_DATA = 16'hABCD;
    repeat (3) @(negedge DCLK);
    chk("rst_do", 32'(DO), 0);
    chk("rst_drdy", 32'(DRDY), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_channel", 32'(CHANNEL), 0);
    chk("rst_eoc", 32'(EOC), 0);
    chk("rst_eos", 32'(EOS), 0);

    // Read 0x41 right after reset release
    RESET = 1'b0; r = cyc;
    drp(7'h41, 1'b0, 16'h0, q, lat, dz);
    chk("rd41_lat", 32'(lat), 4);
    chk("rd41_do", 32'(q), 32'h2EF0);
    chk("rd41_do_idle", 32'(dz), 0);
    @(negedge DCLK);
    chk("do_after_drdy", 32'(DO), 0);
    chk("drdy_pulse", 32'(DRDY), 0);

    // Default sequence
    for (int i = 0; i < 9; i++) begin
      wait_eoc(c);
      if (i == 0) begin
        chk("eoc0_time", 32'(cyc - r), 27);
        chk("busy_next", 32'(BUSY), 0);
      end else chk("eoc_period", 32'(c), 27);
      chk("seq_ch", 32'(CHANNEL), 32'(exp_ch[i]));
      chk("seq_eos", 32'(EOS), 32'(i == 8));
    end
    drp(7'h11, 1'b0, 16'h0, q, lat, dz);
    chk("res11", 32'(q), 32'hABC0);
    drp(7'h11, 1'b1, 16'h5555, q, lat, dz);
    drp(7'h11, 1'b0, 16'h0, q, lat, dz);
    chk("ro_write", 32'(q), 32'hABC0);
    drp(7'h50, 1'b1, 16'h1234, q, lat, dz);
    drp(7'h50, 1'b0, 16'h0, q, lat, dz);
    chk("rw_50", 32'(q), 32'h1234);
    drp(7'h60, 1'b1, 16'hFFFF, q, lat, dz);
    drp(7'h60, 1'b0, 16'h0, q, lat, dz);
    chk("rd_60", 32'(q), 0);

    // Abort ch17 by reconfiguring 0x49
    c = 0;
    for (int i = 0; i < 12; i++) begin
      if (c == 0) begin
        wait_eoc(lat);
        if (CHANNEL == 5'd16) c = 1;
      end
    end
    chk("found_ch16", 32'(c), 1);
    repeat (3) @(negedge DCLK);
    e0 = n_eoc;
    drp(7'h49, 1'b1, 16'h0002, q, lat, dz);
    chk("abort_no_eoc", 32'(n_eoc - e0), 0);
    wait_eoc(c);
    chk("restart_lat", 32'(c), 27);
    chk("restart_ch", 32'(CHANNEL), 0);
    saw16 = 0;
    for (int i = 0; i < 6; i++) begin
      wait_eoc(c);
      if (CHANNEL == 5'd16) saw16++;
      chk("seq2_ch", 32'(CHANNEL), 32'(exp_ch2[i]));
      chk("seq2_eos", 32'(EOS), 32'(exp_ch2[i] == 17));
    end
    chk("no_ch16", 32'(saw16), 0);

    // Single pass
    drp(7'h41, 1'b1, 16'h1EF0, q, lat, dz);
    @(negedge DCLK);
    e0 = n_eoc; s0 = n_eos;
    repeat (300) @(negedge DCLK);
    chk("single_eos", 32'(n_eos - s0), 1);
    chk("single_eoc", 32'(n_eoc - e0), 6);
    chk("halt_ch", 32'(CHANNEL), 17);
    act = 0;
    repeat (60) begin
      @(negedge DCLK);
      if (BUSY || EOC) act++;
    end
    chk("halt_quiet", 32'(act), 0);

    // Overlapping DEN
    DADDR = 7'h40; DWE = 1'b0; DEN = 1'b1;
    @(negedge DCLK);
    @(negedge DCLK);
    DEN = 1'b0; nd = 0; q = '0;
    repeat (10) begin
      @(negedge DCLK);
      if (DRDY) begin nd++; q = DO; end
    end
    chk("dup_drdy", 32'(nd), 1);
    chk("dup_do", 32'(q), 32'h9000);
    drp(7'h3F, 1'b0, 16'h0, q, lat, dz);
    chk("sticky_set", 32'(q), 1);
    drp(7'h3F, 1'b0, 16'h0, q, lat, dz);
    chk("sticky_clr", 32'(q), 0);

    // Reset during a pending access
    DADDR = 7'h40; DEN = 1'b1;
    @(negedge DCLK);
    DEN = 1'b0;
    @(negedge DCLK);
    RESET = 1'b1; SAMPLE_DATA = 16'h4000; nd = 0;
    repeat (2) begin @(negedge DCLK); if (DRDY) nd++; end
    RESET = 1'b0;
    repeat (8) begin @(negedge DCLK); if (DRDY) nd++; end
    chk("rst_abort", 32'(nd), 0);

    // Min/max on ch0 only
    drp(7'h48, 1'b1, 16'h0100, q, lat, dz);
    drp(7'h49, 1'b1, 16'h0000, q, lat, dz);
    wait_eoc(c);
    chk("mm_ch", 32'(CHANNEL), 0);
    SAMPLE_DATA = 16'h8000;
    wait_eoc(c);
    SAMPLE_DATA = 16'h2000;
    wait_eoc(c);
    drp(7'h20, 1'b0, 16'h0, q, lat, dz);
    chk("max_temp", 32'(q), 32'(x20));
    drp(7'h24, 1'b0, 16'h0, q, lat, dz);
    chk("min_temp", 32'(q), 32'(x24));
    drp(7'h21, 1'b0, 16'h0, q, lat, dz);
    chk("max_vcc", 32'(q), 32'(x21));
    drp(7'h25, 1'b0, 16'h0, q, lat, dz);
    chk("min_vcc", 32'(q), 32'(x25));
    drp(7'h00, 1'b0, 16'h0, q, lat, dz);
    chk("res00", 32'(q), 32'h2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
